screen_fade_sequencer: RTL and testbench

//  Selects which of NUM_SCREENS full-screen RGB sources feeds the display; sequences screen changes with a per-frame fade.

---
 rtl/screen_seq_pkg.sv | 23 ++
 rtl/rgb_fade_scale.sv | 14 +
 rtl/screen_fade_sequencer.sv | 154 +++++++++++++++
 tb/tb_screen_fade_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/screen_seq_pkg.sv
// Shared types and constants for the screen fade sequencer.
package screen_seq_pkg;

  typedef enum logic [1:0] {SHOW, FADE_OUT, SWAP, FADE_IN} seq_state_e;

  localparam logic [3:0] FADE_MAX = 4'd15;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Scale one 4-bit channel by (fade+1)/16. An 8-bit product cannot overflow (15*16=240).
  function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [3:0] fade);
    logic [4:0] gain;
    logic [7:0] prod;
    gain = {1'b0, fade} + 5'd1;
    prod = {4'b0000, c} * {3'b000, gain};
    return prod[7:4];
  endfunction

endpackage

// File: rtl/rgb_fade_scale.sv
// Combinational per-channel fade of one 12-bit RGB pixel; the caller registers the result.
module rgb_fade_scale
  import screen_seq_pkg::*;
(
  input  rgb12_t     pix,
  input  logic [3:0] fade,
  output rgb12_t     scaled
);

  assign scaled.r = scale_chan(pix.r, fade);
  assign scaled.g = scale_chan(pix.g, fade);
  assign scaled.b = scale_chan(pix.b, fade);

endmodule

// File: rtl/screen_fade_sequencer.sv
// Selects one of NUM_SCREENS RGB sources and sequences changes as fade-out, swap, fade-in.
// Optional macro SCREEN_QUEUE_EN adds a one-entry pending request register.
module screen_fade_sequencer
  import screen_seq_pkg::*;
#(
  parameter int WIDTH           = 640,
  parameter int HEIGHT          = 480,
  parameter int NUM_SCREENS     = 4,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic                           clk_25,
  input  logic                           reset,
  input  logic [$clog2(WIDTH)-1:0]       pxl_x,
  input  logic [$clog2(HEIGHT)-1:0]      pxl_y,
  input  logic                           req_valid,
  input  logic [$clog2(NUM_SCREENS)-1:0] req_screen,
  output logic                           req_ready,
  input  logic [12*NUM_SCREENS-1:0]      src_rgb,
  output logic [3:0]                     Red_level,
  output logic [3:0]                     Green_level,
  output logic [3:0]                     Blue_level,
  output logic [$clog2(NUM_SCREENS)-1:0] cur_screen,
  output logic                           busy
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int SW = $clog2(NUM_SCREENS);
  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  seq_state_e    state, state_d;
  logic [3:0]    fade, fade_d;
  logic [CW-1:0] step_cnt;
  logic          frame_tick;
  logic          step;
  logic          accept;
  logic [SW-1:0] target, target_d;
  logic [SW-1:0] cur_d;
  rgb12_t        src_pix, scaled_pix, rgb_q;

  function automatic logic is_new_screen(input logic [SW-1:0] s, input logic [SW-1:0] cur);
    return (32'(s) < NUM_SCREENS) && (s != cur);
  endfunction

  // Last visible pixel of the frame: the tick lands in blanking, so fades never tear a frame.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) frame_tick <= 1'b0;
    else       frame_tick <= (pxl_x == XW'(WIDTH - 1)) && (pxl_y == YW'(HEIGHT - 1));
  end

  assign step   = frame_tick && (step_cnt == CW'(FRAMES_PER_STEP - 1));
  assign accept = req_valid && req_ready;
  assign busy   = (state != SHOW);

`ifdef SCREEN_QUEUE_EN
  logic          pending_valid;
  logic [SW-1:0] pending_screen;

  assign req_ready = !reset && !pending_valid;

  // In SHOW the pending entry is consumed; elsewhere an accepted request is parked here.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      pending_valid  <= 1'b0;
      pending_screen <= '0;
    end else if (state == SHOW && pending_valid) begin
      pending_valid  <= 1'b0;
    end else if (accept && state != SHOW) begin
      pending_valid  <= 1'b1;
      pending_screen <= req_screen;
    end
  end
`else
  assign req_ready = !reset && (state == SHOW);
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case, so no latch can be inferred.
    state_d  = state;
    fade_d   = fade;
    target_d = target;
    cur_d    = cur_screen;
    case (state)
      SHOW: begin
`ifdef SCREEN_QUEUE_EN
        if (pending_valid) begin
          if (is_new_screen(pending_screen, cur_screen)) begin
            target_d = pending_screen;
            state_d  = FADE_OUT;
          end
        end else if (accept && is_new_screen(req_screen, cur_screen)) begin
          target_d = req_screen;
          state_d  = FADE_OUT;
        end
`else
        if (accept && is_new_screen(req_screen, cur_screen)) begin
          target_d = req_screen;
          state_d  = FADE_OUT;
        end
`endif
      end
      FADE_OUT: begin
        if (step) begin
          if (fade != 4'd0) fade_d  = fade - 4'd1;
          else              state_d = SWAP;
        end
      end
      SWAP: begin
        cur_d   = target;
        state_d = FADE_IN;
      end
      FADE_IN: begin
        if (step) begin
          if (fade != FADE_MAX) fade_d = fade + 4'd1;
          if (fade_d == FADE_MAX) state_d = SHOW;
        end
      end
      default: state_d = FADE_IN;
    endcase
  end

  assign src_pix = src_rgb[32'(cur_screen) * 12 +: 12];

  rgb_fade_scale u_scale (
    .pix    (src_pix),
    .fade   (fade),
    .scaled (scaled_pix)
  );

  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state      <= FADE_IN;
      fade       <= 4'd0;
      step_cnt   <= '0;
      target     <= '0;
      cur_screen <= '0;
      rgb_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state      <= state_d;
      fade       <= fade_d;
      target     <= target_d;
      cur_screen <= cur_d;
      rgb_q      <= scaled_pix;
      if (step || state_d != state) step_cnt <= '0;
      else if (frame_tick)          step_cnt <= step_cnt + CW'(1);
    end
  end

  assign Red_level   = rgb_q.r;
  assign Green_level = rgb_q.g;
  assign Blue_level  = rgb_q.b;

endmodule

// File: tb/tb_screen_fade_sequencer.sv
// Directed self-checking bench for screen_fade_sequencer (8x4 frame, 4 screens, 1 frame per step).
module tb_screen_fade_sequencer;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = 4;
  localparam int F = 1;
`ifdef SCREEN_QUEUE_EN
  localparam bit QUEUE = 1'b1;
`else
  localparam bit QUEUE = 1'b0;
`endif

  localparam logic [11:0] SRC0 = 12'hF84;
  localparam logic [11:0] SRC1 = 12'h5A6;
  localparam logic [11:0] SRC2 = 12'h9C3;
  localparam logic [11:0] SRC3 = 12'h2E7;

  logic        clk_25 = 1'b0;
  logic        reset;
  logic [2:0]  pxl_x;
  logic [1:0]  pxl_y;
  logic        req_valid;
  logic [1:0]  req_screen;
  logic        req_ready;
  logic [47:0] src_rgb;
  logic [3:0]  Red_level, Green_level, Blue_level;
  logic [1:0]  cur_screen;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  screen_fade_sequencer #(
    .WIDTH(W), .HEIGHT(H), .NUM_SCREENS(N), .FRAMES_PER_STEP(F)
  ) dut (
    .clk_25      (clk_25),
    .reset       (reset),
    .pxl_x       (pxl_x),
    .pxl_y       (pxl_y),
    .req_valid   (req_valid),
    .req_screen  (req_screen),
    .req_ready   (req_ready),
    .src_rgb     (src_rgb),
    .Red_level   (Red_level),
    .Green_level (Green_level),
    .Blue_level  (Blue_level),
    .cur_screen  (cur_screen),
    .busy        (busy)
  );

  always #20 clk_25 = ~clk_25;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rgb_out();
    return {20'd0, Red_level, Green_level, Blue_level};
  endfunction

  // One frame tick; returns on the negedge after fade/state have updated.
  task automatic tick();
    @(negedge clk_25); pxl_x = 3'd7; pxl_y = 2'd3;
    @(negedge clk_25); pxl_x = 3'd0; pxl_y = 2'd0;
    @(negedge clk_25);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_req(input logic [1:0] s);
    @(negedge clk_25); req_valid = 1'b1; req_screen = s;
    @(negedge clk_25); req_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    pxl_x      = 3'd0;
    pxl_y      = 2'd0;
    req_valid  = 1'b0;
    req_screen = 2'd0;
    src_rgb    = {SRC3, SRC2, SRC1, SRC0};

    // Reset held for 3 cycles
    repeat (3) @(negedge clk_25);
    check("rst_rgb",   rgb_out(),  32'h000);
    check("rst_busy",  busy,       32'd1);
    check("rst_ready", req_ready,  32'd0);
    check("rst_cur",   cur_screen, 32'd0);
    reset = 1'b0;
    @(negedge clk_25);
    check("pwr_busy",  busy,      32'd1);
    check("pwr_ready", req_ready, 32'(QUEUE));
    check("pwr_rgb",   rgb_out(), 32'h000);

    // Freeze power-up fade at 7
    ticks(7);
    @(negedge clk_25);
    check("fade7_f84", rgb_out(), 32'h742);
    src_rgb[11:0] = 12'hFFF;
    repeat (2) @(negedge clk_25);
    check("fade7_fff", rgb_out(), 32'h777);
    src_rgb[11:0] = SRC0;

    ticks(7);
    check("fade14_busy", busy, 32'd1);
    tick();
    check("show_ready", req_ready, 32'd1);
    check("show_busy",  busy,      32'd0);
    check("show_rgb_lag", rgb_out(), 32'hE73);
    @(negedge clk_25);
    check("show_rgb", rgb_out(), 32'hF84);

    // Change to screen 2
    pulse_req(2'd2);
    check("req2_busy",  busy,       32'd1);
    check("req2_ready", req_ready,  32'(QUEUE));
    check("req2_cur",   cur_screen, 32'd0);
    tick();
    @(negedge clk_25);
    check("out_t1_rgb", rgb_out(), 32'hE73);
    for (int i = 2; i <= 15; i++) begin
      tick();
      if (i == 8) begin
        @(negedge clk_25);
        check("out_t8_rgb", rgb_out(), 32'h742);
      end
    end
    @(negedge clk_25);
    check("out_t15_rgb", rgb_out(),  32'h000);
    check("out_t15_cur", cur_screen, 32'd0);
    tick();
    check("swap_cur_old", cur_screen, 32'd0);
    @(negedge clk_25);
    check("swap_cur_new", cur_screen, 32'd2);
    check("swap_rgb",     rgb_out(),  32'h000);
    ticks(14);
    check("in_t30_busy", busy, 32'd1);
    tick();
    check("in_t31_busy",  busy,      32'd0);
    check("in_t31_ready", req_ready, 32'd1);
    @(negedge clk_25);
    check("src2_rgb", rgb_out(), 32'h9C3);

    // Request for the screen already shown is accepted and dropped
    @(negedge clk_25); req_valid = 1'b1; req_screen = 2'd2;
    check("same_ready", req_ready, 32'd1);
    @(negedge clk_25); req_valid = 1'b0;
    check("same_busy", busy,       32'd0);
    check("same_cur",  cur_screen, 32'd2);
    repeat (3) @(negedge clk_25);
    check("same_busy2", busy, 32'd0);

    // Reset mid fade-out at fade=9
    pulse_req(2'd1);
    ticks(6);
    @(negedge clk_25);
    check("fade9_rgb", rgb_out(), 32'h571);
    reset = 1'b1;
    #1;
    check("midrst_rgb",   rgb_out(),  32'h000);
    check("midrst_cur",   cur_screen, 32'd0);
    check("midrst_busy",  busy,       32'd1);
    check("midrst_ready", req_ready,  32'd0);
    @(negedge clk_25); reset = 1'b0;
    ticks(15);
    check("rst2_show", busy, 32'd0);
    @(negedge clk_25);
    check("rst2_rgb", rgb_out(), 32'hF84);

    // Second request during a fade
    pulse_req(2'd1);
    ticks(3);
    @(negedge clk_25); req_valid = 1'b1; req_screen = 2'd3;
    check("q_ready", req_ready, 32'(QUEUE));
    @(negedge clk_25); req_valid = 1'b0;
    ticks(13);
    @(negedge clk_25);
    check("q_cur1", cur_screen, 32'd1);
    ticks(15);
    check("q_show1", busy, 32'd0);
    @(negedge clk_25);
    check("q_next_busy", busy, 32'(QUEUE));
    if (QUEUE) begin
      ticks(16);
      @(negedge clk_25);
      check("q_cur3", cur_screen, 32'd3);
    end else begin
      repeat (4) @(negedge clk_25);
      check("q_cur_stay", cur_screen, 32'd1);
      check("q_src1_rgb", rgb_out(),  32'h5A6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
